// File: rtl/afifo_wr_arbiter_if.sv
// Write-port arbiter bundle: requester handshake plus FIFO write-side signals.
// master = arbiter side, slave = requesters/FIFO side.
interface afifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [IDW+WIDTH-1:0]  fifo_wr_data;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  burst_done;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ack, fifo_wr_en, fifo_wr_data, grant_id, busy, burst_done
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ack, fifo_wr_en, fifo_wr_data, grant_id, busy, burst_done
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters
// in bounded bursts; every word is tagged with its source ID.
module afifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic                clk1,
    input  logic                rst1,
    afifo_wr_arbiter_if.master  bus
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             wr_en;
    logic [IDW-1:0]   pick;
    logic             found;
    int               idx;

    // Owner's payload/valid; loop mux keeps all indices constant after unroll.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_data  = bus.req_data[i*WIDTH +: WIDTH];
                sel_valid = bus.req_valid[i];
            end
        end
    end

    // First valid requester scanning circularly from last_owner+1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == idx) && bus.req_valid[j]) begin
                    pick  = IDW'(j);
                    found = 1'b1;
                end
            end
        end
    end

    assign wr_en = (state_q == S_BURST) && sel_valid && !bus.fifo_full;

    for (genvar g = 0; g < NREQ; g++) begin : g_ack
        assign bus.req_ack[g] = wr_en && (grant_q == IDW'(g));
    end

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = {grant_q, sel_data};
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;
    assign bus.burst_done   = done_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_BURST;
                    grant_d = pick;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // A dropped valid or the last allowed word both close the grant.
                if (!sel_valid || (wr_en && cnt_q == CW'(BURST-1))) begin
                    state_d = S_IDLE;
                    last_d  = grant_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NREQ-1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level round-robin model.
module tb_afifo_wr_arbiter;
    localparam int NREQ = 4, IDW = 2, WIDTH = 4, BURST = 4;

    logic clk1 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk1 = ~clk1;

    afifo_wr_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) bus();
    afifo_wr_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk1(clk1), .rst1(rst1), .bus(bus)
    );

    logic [3:0] vld = '0;
    logic [3:0] dat [4];
    logic       full = 1'b0;
    assign bus.req_valid = vld;
    assign bus.fifo_full = full;
    assign bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};

    int total = 0, bad = 0;
    logic [5:0] wlog [$];
    logic [3:0] ack_s;

    // Reference model: owner=-1 means nobody holds the port.
    int m_owner, m_last, m_cnt, m_gid;
    bit m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_last = NREQ - 1; m_cnt = 0; m_gid = 0; m_done = 0;
    endtask

    function automatic bit vbit(input int i);
        return vld[i[1:0]];
    endfunction

    function automatic bit m_wr();
        return rst1 && (m_owner >= 0) && vbit(m_owner) && !full;
    endfunction

    task automatic m_step();
        bit wr;
        wr = m_wr();
        if (!rst1) begin
            m_reset();
        end else if (m_owner < 0) begin
            m_done = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (vbit((m_last + k) % NREQ)) begin
                    m_owner = (m_last + k) % NREQ;
                    break;
                end
            end
            if (m_owner >= 0) begin m_gid = m_owner; m_cnt = 0; end
        end else if (!vbit(m_owner)) begin
            m_last = m_owner; m_owner = -1; m_done = 1;
        end else if (wr) begin
            m_cnt++;
            m_done = 0;
            if (m_cnt == BURST) begin m_last = m_owner; m_owner = -1; m_done = 1; end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        bit wr;
        logic [3:0] eack;
        wr = m_wr();
        eack = wr ? (4'b1 << m_owner) : 4'b0;
        chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(wr));
        chk({tag, ".ack"}, 32'(bus.req_ack), 32'(eack));
        if (wr) chk({tag, ".wdata"}, 32'(bus.fifo_wr_data), 32'({m_owner[1:0], dat[m_owner[1:0]]}));
        chk({tag, ".gid"}, 32'(bus.grant_id), 32'(m_gid[1:0]));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
        chk({tag, ".done"}, 32'(bus.burst_done), 32'(m_done));
    endtask

    // One clock: sample mid-cycle, advance model, step past the edge.
    task automatic cyc(input bit use_model, input string tag);
        #4;
        if (use_model) chk_model(tag);
        ack_s = bus.req_ack;
        if (bus.fifo_wr_en) wlog.push_back(bus.fifo_wr_data);
        m_step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst1 = 1'b0; vld = '0; full = 1'b0;
        cyc(0, "rst");
        rst1 = 1'b1;
    endtask

    typedef struct {
        bit rst; logic [3:0] v; bit full;
        logic [3:0] ack; bit wr; logic [5:0] wd; logic [1:0] gid; bit busy; bit done;
    } vec_t;
    vec_t tbl [20];

    function automatic vec_t mk(bit r, logic [3:0] v, bit f, logic [3:0] a, bit w,
                                logic [5:0] wd, logic [1:0] g, bit b, bit d);
        vec_t x;
        x.rst = r; x.v = v; x.full = f; x.ack = a; x.wr = w; x.wd = wd;
        x.gid = g; x.busy = b; x.done = d;
        return x;
    endfunction

    initial begin
        int ew, n, c1;
        logic [5:0] w;
        dat[0] = 4'h9; dat[1] = 4'hA; dat[2] = 4'hB; dat[3] = 4'hC;
        m_reset();

        // Reset with all valid, grant 0 burst, stall on full, early drop by 3.
        tbl[0]  = mk(0, 4'hF, 0, 4'h0, 0, 6'h00, 0, 0, 0);
        tbl[1]  = mk(0, 4'hF, 0, 4'h0, 0, 6'h00, 0, 0, 0);
        tbl[2]  = mk(1, 4'hF, 0, 4'h0, 0, 6'h00, 0, 0, 0);
        for (int r = 3; r <= 6; r++) tbl[r] = mk(1, 4'hF, 0, 4'h1, 1, 6'h09, 0, 1, 0);
        tbl[7]  = mk(1, 4'h2, 0, 4'h0, 0, 6'h00, 0, 0, 1);
        tbl[8]  = mk(1, 4'h2, 0, 4'h2, 1, 6'h1A, 1, 1, 0);
        tbl[9]  = mk(1, 4'h2, 0, 4'h2, 1, 6'h1A, 1, 1, 0);
        for (int r = 10; r <= 12; r++) tbl[r] = mk(1, 4'h2, 1, 4'h0, 0, 6'h00, 1, 1, 0);
        tbl[13] = mk(1, 4'h2, 0, 4'h2, 1, 6'h1A, 1, 1, 0);
        tbl[14] = mk(1, 4'h2, 0, 4'h2, 1, 6'h1A, 1, 1, 0);
        tbl[15] = mk(1, 4'h9, 0, 4'h0, 0, 6'h00, 1, 0, 1);
        tbl[16] = mk(1, 4'h9, 0, 4'h8, 1, 6'h3C, 3, 1, 0);
        tbl[17] = mk(1, 4'h1, 0, 4'h0, 0, 6'h00, 3, 1, 0);
        tbl[18] = mk(1, 4'h1, 0, 4'h0, 0, 6'h00, 3, 0, 1);
        tbl[19] = mk(1, 4'h1, 0, 4'h1, 1, 6'h09, 0, 1, 0);

        for (int r = 0; r < 20; r++) begin
            rst1 = tbl[r].rst; vld = tbl[r].v; full = tbl[r].full;
            #4;
            chk($sformatf("tbl%0d.ack", r), 32'(bus.req_ack), 32'(tbl[r].ack));
            chk($sformatf("tbl%0d.wr_en", r), 32'(bus.fifo_wr_en), 32'(tbl[r].wr));
            if (tbl[r].wr) chk($sformatf("tbl%0d.wdata", r), 32'(bus.fifo_wr_data), 32'(tbl[r].wd));
            chk($sformatf("tbl%0d.gid", r), 32'(bus.grant_id), 32'(tbl[r].gid));
            chk($sformatf("tbl%0d.busy", r), 32'(bus.busy), 32'(tbl[r].busy));
            chk($sformatf("tbl%0d.done", r), 32'(bus.burst_done), 32'(tbl[r].done));
            chk_model($sformatf("tbl%0d.model", r));
            m_step();
            @(posedge clk1);
            #1;
        end

        // Single requester 2 streaming 1..8: two bursts of 4 with one idle gap.
        do_reset();
        vld = 4'b0100; dat[2] = 4'd1; n = 1;
        for (int c = 0; c < 10; c++) begin
            #4;
            ew = (c != 0 && c != 5) ? 1 : 0;
            chk($sformatf("solo%0d.wr_en", c), 32'(bus.fifo_wr_en), 32'(ew));
            if (ew != 0) chk($sformatf("solo%0d.wdata", c), 32'(bus.fifo_wr_data), 32'({2'd2, 4'(n)}));
            chk($sformatf("solo%0d.done", c), 32'(bus.burst_done), 32'(c == 5));
            if (c != 0) chk($sformatf("solo%0d.busy", c), 32'(bus.busy), 32'(c != 5));
            if (c != 0) chk($sformatf("solo%0d.gid", c), 32'(bus.grant_id), 32'd2);
            m_step();
            @(posedge clk1);
            #1;
            if (ew != 0) begin n++; dat[2] = 4'(n); end
        end
        chk("solo.count", 32'(n - 1), 32'd8);

        // All four continuously valid: round robin 0,1,2,3,0 with 4 words each.
        do_reset();
        vld = 4'hF;
        wlog.delete();
        for (int c = 0; c < 25; c++) begin
            cyc(1, "rr");
            for (int i = 0; i < 4; i++) if (ack_s[i]) dat[i] = 4'($urandom);
        end
        chk("rr.count", 32'(wlog.size()), 32'd20);
        for (int k = 0; k < wlog.size() && k < 20; k++) begin
            w = wlog[k];
            chk($sformatf("rr.order%0d", k), 32'(w[5:4]), 32'((k / 4) % 4));
        end

        // Async reset pulse mid-burst after two words of requester 1.
        do_reset();
        vld = 4'b0010;
        wlog.delete();
        for (int c = 0; c < 3; c++) cyc(1, "mid");
        #2;
        rst1 = 1'b0;
        #1;
        chk("midrst.wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("midrst.ack", 32'(bus.req_ack), 32'd0);
        chk("midrst.gid", 32'(bus.grant_id), 32'd0);
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.burst_done), 32'd0);
        m_reset();
        @(posedge clk1);
        #1;
        rst1 = 1'b1;
        vld = 4'b0011;
        cyc(1, "mid.arb");
        cyc(1, "mid.w");
        chk("mid.regrant", 32'(bus.grant_id), 32'd0);
        c1 = 0;
        foreach (wlog[k]) begin
            w = wlog[k];
            if (w[5:4] == 2'd1) c1++;
        end
        chk("mid.aborted_words", 32'(c1), 32'd2);

        // Randomized traffic with legal early drops and random full.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            full = ($urandom_range(3) == 0);
            cyc(1, "rnd");
            for (int i = 0; i < 4; i++) begin
                if (ack_s[i]) begin
                    vld[i] = 1'($urandom_range(1));
                    dat[i] = 4'($urandom);
                end else if (vld[i]) begin
                    if ($urandom_range(7) == 0) vld[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    vld[i] = 1'b1;
                    dat[i] = 4'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
Round-robin write-port arbiter in the clk1 (write) domain of the async FIFO. It shares the FIFO's single write port among NREQ requesters using bounded bursts. Each written word is tagged with the source ID so the read domain can demultiplex. It drives the FIFO's write-enable and write-data, and throttles on the FIFO's registered full flag.

Parameters:
NREQ, 4, number of requesters (>=2)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
WIDTH, 4, payload width per requester
BURST, 4, maximum words per grant (>=1)

Ports:
clk1  in  1  write-domain clock
rst1  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  bit i: requester i has a word on req_data
req_data  in  NREQ*WIDTH  flat payload; requester i at [i*WIDTH +: WIDTH]
req_ack  out  NREQ  one-hot, combinational; word of requester i accepted this cycle
fifo_full  in  1  registered full flag from FIFO write side
fifo_wr_en  out  1  FIFO write enable, combinational
fifo_wr_data  out  IDW+WIDTH  {grant_id, payload}, combinational
grant_id  out  IDW  registered current owner
busy  out  1  registered; 1 while in BURST
burst_done  out  1  registered one-cycle pulse after a grant ends

Behaviour:
- Reset (rst1=0, async): state=IDLE, grant_id=0, busy=0, burst_done=0, cnt=0, last_owner=NREQ-1. req_ack=0 and fifo_wr_en=0 follow from IDLE. After reset, requester 0 has highest priority.
- Handshake: a requester holds req_valid and stable req_data until req_ack. Deasserting req_valid before ack is legal and ends that requester's grant.
- IDLE:
  - No writes.
  - If any req_valid bit is set: go to BURST; grant_id <= first valid index searching circularly from last_owner+1; cnt <= 0; busy <= 1.
  - Else stay.
- BURST:
  - fifo_wr_en = req_valid[grant_id] && !fifo_full.
  - req_ack[grant_id] = fifo_wr_en; all other ack bits are 0.
  - fifo_wr_data = {grant_id, req_data[grant_id]}.
  - Accept with cnt==BURST-1: go to IDLE; last_owner <= grant_id; burst_done <= 1; busy <= 0.
  - Accept with cnt<BURST-1: cnt <= cnt+1.
  - !req_valid[grant_id]: go to IDLE (no write this cycle); last_owner <= grant_id; burst_done <= 1; busy <= 0.
  - req_valid && fifo_full: stall. Hold grant and cnt; no ack; no write. No timeout.
- Latency: first write occurs the cycle after entering BURST, i.e. 2 cycles after req_valid rises from IDLE. Each grant is followed by exactly one IDLE arbitration cycle. Peak throughput is BURST/(BURST+1).
- Other requesters' req_valid changes during BURST are ignored until the next IDLE cycle.
- Counter: sized for 0..BURST-1 (min 1 bit). With BURST=1, every accept ends the grant.
- fifo_full is trusted as-is; the arbiter never writes while it is 1, so FIFO overflow cannot originate here.
- Reset mid-burst: immediate return to reset state. Words already written stay in the FIFO; the unacked word is not written.
- grant_id holds its last value in IDLE, but fifo_wr_en=0 there.

Test Plan:
- Reset: hold rst1=0 with all req_valid=1 -> req_ack=0, fifo_wr_en=0, grant_id=0, busy=0. After release: cycle 1 grants 0, cycle 2 writes {2'd0, data0}.
- Single requester 2, continuously valid, data 1..8 -> writes {2'd2,1}..{2'd2,4}, burst_done pulse, 1 idle cycle, regrant 2, writes 5..8.
- All four valid continuously -> grant order 0,1,2,3,0, each grant exactly 4 writes, 1 idle cycle between grants, ack one-hot and matching grant_id.
- Requester 1 granted, fifo_full=1 for 3 cycles after 2 writes -> no wr_en/ack for those 3 cycles, grant_id=1 held, cnt frozen at 2, then 2 more writes and release.
- Requester 3 drops req_valid after 1 write while requester 0 is valid -> grant ends with 1 word, burst_done pulses, next grant is 0 (circular from 3).
- rst1 pulsed low for 1 cycle mid-burst after 2 writes -> outputs return to reset values asynchronously; after release, arbitration restarts at requester 0; exactly 2 words from the aborted burst were written.
